intc_ahb_mst: RTL and testbench
===============================

Name: intc_ahb_mst

Overview:
- Single-outstanding AHB-Lite master that turns a simple request/response interface into 32-bit SINGLE NONSEQ transfers.
- It is the initiator counterpart to the interrupt-controller register slave.
- Used by on-chip agents (DMA helper, test sequencer) to read and write intc and peripheral registers over the system AHB.
- Includes misalignment rejection, ERROR-response handling and a sticky data-phase wait-timeout monitor.

Parameters:
- AHB_AW, 32, address width.
- AHB_DW, 32, data width (only 32 supported).
- MAX_WAIT, 1024, data-phase wait cycles tolerated before the timeout flag sets.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_i  in  1  request valid
- req_wr_i  in  1  1=write, 0=read
- req_addr_i  in  AHB_AW  byte address
- req_wdata_i  in  AHB_DW  write data
- req_gnt_o  out  1  request accepted this cycle
- rsp_vld_o  out  1  one-cycle response strobe
- rsp_err_o  out  1  response is error (valid with rsp_vld_o)
- rsp_rdata_o  out  AHB_DW  read data (valid with rsp_vld_o on reads)
- busy_o  out  1  FSM not IDLE
- tmo_o  out  1  sticky wait-timeout flag
- tmo_clr_i  in  1  clears tmo_o
- haddr_o  out  AHB_AW  AHB address
- hwrite_o  out  1  AHB write
- htrans_o  out  2  AHB transfer type
- hsize_o  out  3  constant 3'b010
- hburst_o  out  3  constant 3'b000
- hmastlock_o  out  1  constant 0
- hwdata_o  out  AHB_DW  AHB write data
- hready_i  in  1  AHB ready
- hresp_i  in  2  AHB response (00 OKAY, 01 ERROR)
- hrdata_i  in  AHB_DW  AHB read data

Behaviour:
- One clock, clk. Reset rst is synchronous, active-high.
- Reset values: FSM=IDLE, htrans_o=2'b00, haddr_o=0, hwrite_o=0, hwdata_o=0, rsp_vld_o=0, rsp_err_o=0, rsp_rdata_o=0, tmo_o=0, wait counter=0.
- req_gnt_o = req_i & (state==IDLE), combinational.
- On grant: capture addr, wr and wdata into registers.
- FSM states:
  - IDLE:
    - On grant with req_addr_i[1:0]!=0 (misaligned): no bus cycle; next cycle rsp_vld_o=1, rsp_err_o=1; stay IDLE.
    - On grant with aligned address: go to ADDR.
  - ADDR:
    - Drive htrans_o=NONSEQ, haddr_o=captured addr, hwrite_o=captured wr.
    - hready_i=0: hold all of these stable.
    - hready_i=1: go to DATA.
  - DATA:
    - htrans_o=IDLE; hwdata_o=captured wdata (held through wait states).
    - Wait while hready_i=0.
    - hready_i=0 & hresp_i=ERROR: go to ERR.
    - hready_i=1 & hresp_i=OKAY: next cycle rsp_vld_o=1, rsp_err_o=0, rsp_rdata_o=hrdata_i (reads; writes leave rsp_rdata_o unchanged); go to IDLE.
    - hready_i=1 & hresp_i=ERROR without a preceding hready_i=0 cycle (protocol violation): treated as error response.
  - ERR (second ERROR cycle):
    - Wait for hready_i=1, then next cycle rsp_vld_o=1, rsp_err_o=1; go to IDLE.
    - rsp_rdata_o unchanged.
- rsp_vld_o is a single-cycle registered strobe.
- The FSM is already IDLE during the rsp_vld_o cycle, so a new request may be granted in that same cycle.
- Zero-wait latency: grant edge N → address phase cycle N+1 → data phase cycle N+2 → rsp_vld_o in cycle N+3. Each wait state adds one cycle.
- Wait counter:
  - Increments each DATA/ERR cycle with hready_i=0; clears on leaving DATA/ERR.
  - Saturates at MAX_WAIT.
  - On reaching MAX_WAIT, sets tmo_o. The transfer is NOT aborted (AHB forbids it).
- tmo_o:
  - Cleared by tmo_clr_i.
  - Set has priority over clear in the same cycle.
- busy_o = (state!=IDLE).
- Reset mid-transfer: return to reset values immediately; no response is issued for the in-flight request; htrans_o=IDLE on the next cycle.
- req_i while busy: not granted; the requester holds request fields stable until granted.

Test Plan:
- Aligned write addr 0x1000_0010, data 0xA5A5_5A5A, zero wait → htrans_o NONSEQ at N+1, hwdata_o=0xA5A5_5A5A at N+2, rsp_vld_o=1, rsp_err_o=0 at N+3.
- Aligned read addr 0x1000_0004, slave inserts 3 wait states, hrdata_i=0x0000_00FF → rsp_vld_o at N+6, rsp_rdata_o=0x0000_00FF; addr and wdata held during waits.
- Read addr 0x1000_0002 → no NONSEQ on bus, rsp_vld_o=1, rsp_err_o=1 at N+1.
- Write with two-cycle ERROR response (hready_i 0 then 1 with hresp_i=01) → rsp_err_o=1, FSM IDLE; next request granted in the rsp_vld_o cycle.
- MAX_WAIT=4, slave stalls 6 cycles → tmo_o=1 after 4th wait cycle; transfer still completes with rsp_vld_o; tmo_clr_i pulse → tmo_o=0.
- Assert rst during DATA wait state → outputs at reset values next cycle; no rsp_vld_o; fresh request afterwards completes normally.

Source files
------------

// File: rtl/intc_ahb_mst.sv
// Single-outstanding AHB-Lite master: turns a request/response handshake into
// 32-bit SINGLE NONSEQ transfers, with misalignment rejection and a wait-timeout flag.
module intc_ahb_mst #(
    parameter int AHB_AW   = 32,
    parameter int AHB_DW   = 32,
    parameter int MAX_WAIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              req_wr_i,
    input  logic [AHB_AW-1:0] req_addr_i,
    input  logic [AHB_DW-1:0] req_wdata_i,
    output logic              req_gnt_o,
    output logic              rsp_vld_o,
    output logic              rsp_err_o,
    output logic [AHB_DW-1:0] rsp_rdata_o,
    output logic              busy_o,
    output logic              tmo_o,
    input  logic              tmo_clr_i,
    output logic [AHB_AW-1:0] haddr_o,
    output logic              hwrite_o,
    output logic [1:0]        htrans_o,
    output logic [2:0]        hsize_o,
    output logic [2:0]        hburst_o,
    output logic              hmastlock_o,
    output logic [AHB_DW-1:0] hwdata_o,
    input  logic              hready_i,
    input  logic [1:0]        hresp_i,
    input  logic [AHB_DW-1:0] hrdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam int            CW    = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] W_MAX = CW'(MAX_WAIT);
    localparam logic [CW-1:0] W_SET = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] W_ONE = CW'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AHB_AW-1:0] r_addr;
    logic              r_wr;
    logic [AHB_DW-1:0] r_wdata;
    logic              r_rsp_vld;
    logic              r_rsp_err;
    logic [AHB_DW-1:0] r_rdata;
    logic              r_tmo;
    logic [CW-1:0]     r_wcnt;

    logic w_gnt;
    logic w_misal;
    logic w_herr;
    logic w_wait;
    logic w_tmo_set;
    logic w_rsp_vld;
    logic w_rsp_err;
    logic w_rdata_ld;

    assign w_gnt     = req_i && (r_state == S_IDLE);
    assign w_misal   = (req_addr_i[1:0] != 2'b00);
    assign w_herr    = (hresp_i == 2'b01);
    assign w_wait    = ((r_state == S_DATA) || (r_state == S_ERR)) && !hready_i;
    // Fires on the wait cycle that brings the count to MAX_WAIT (and while saturated).
    assign w_tmo_set = w_wait && (r_wcnt >= W_SET);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rsp_vld   = 1'b0;
        w_rsp_err   = 1'b0;
        w_rdata_ld  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt) begin
                    if (w_misal) begin
                        w_rsp_vld = 1'b1;
                        w_rsp_err = 1'b1;
                    end else begin
                        w_state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (hready_i) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (hready_i) begin
                    // A one-cycle ERROR (no leading wait) is still reported as an error.
                    w_rsp_vld   = 1'b1;
                    w_state_nxt = S_IDLE;
                    if (w_herr) begin
                        w_rsp_err = 1'b1;
                    end else if (!r_wr) begin
                        w_rdata_ld = 1'b1;
                    end
                end else if (w_herr) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                if (hready_i) begin
                    w_rsp_vld   = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rdata   <= '0;
            r_tmo     <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            if (w_gnt) begin
                r_addr  <= req_addr_i;
                r_wr    <= req_wr_i;
                r_wdata <= req_wdata_i;
            end
            r_rsp_vld <= w_rsp_vld;
            r_rsp_err <= w_rsp_err;
            if (w_rdata_ld) r_rdata <= hrdata_i;
            if (w_wait) begin
                if (r_wcnt != W_MAX) r_wcnt <= r_wcnt + W_ONE;
            end else begin
                r_wcnt <= '0;
            end
            if (w_tmo_set) begin
                r_tmo <= 1'b1;
            end else if (tmo_clr_i) begin
                r_tmo <= 1'b0;
            end
        end
    end

    assign req_gnt_o   = w_gnt;
    assign rsp_vld_o   = r_rsp_vld;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rdata;
    assign busy_o      = (r_state != S_IDLE);
    assign tmo_o       = r_tmo;
    assign haddr_o     = r_addr;
    assign hwrite_o    = r_wr;
    assign htrans_o    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
    assign hsize_o     = 3'b010;
    assign hburst_o    = 3'b000;
    assign hmastlock_o = 1'b0;
    assign hwdata_o    = r_wdata;

endmodule

// File: tb/tb_intc_ahb_mst.sv
// Self-checking bench for intc_ahb_mst: directed scenarios plus randomized transfers
// checked against a cycle-timeline reference model of the request/response behaviour.
module tb_intc_ahb_mst;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, req_wr_i, tmo_clr_i, hready_i;
    logic [31:0] req_addr_i, req_wdata_i, hrdata_i;
    logic [1:0]  hresp_i;
    logic        req_gnt_o, rsp_vld_o, rsp_err_o, busy_o, tmo_o, hwrite_o, hmastlock_o;
    logic [31:0] rsp_rdata_o, haddr_o, hwdata_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hsize_o, hburst_o;

    int          n_chk = 0;
    int          n_err = 0;
    bit          pend = 1'b0;
    bit          pend_err = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    bit          m_tmo = 1'b0;

    intc_ahb_mst #(.AHB_AW(32), .AHB_DW(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_gnt_o(req_gnt_o), .rsp_vld_o(rsp_vld_o), .rsp_err_o(rsp_err_o),
        .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o), .tmo_o(tmo_o), .tmo_clr_i(tmo_clr_i),
        .haddr_o(haddr_o), .hwrite_o(hwrite_o), .htrans_o(htrans_o), .hsize_o(hsize_o),
        .hburst_o(hburst_o), .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o),
        .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // One bus-idle cycle; also consumes any response due in this cycle.
    task automatic idle_cycle(input bit clr);
        @(posedge clk); #1;
        req_i = 1'b0; hready_i = 1'b1; hresp_i = 2'b00; tmo_clr_i = clr;
        @(negedge clk);
        n_chk++; if (rsp_vld_o !== pend) begin n_err++; $display("FAIL idle_rsp_vld: got %b want %b", rsp_vld_o, pend); end
        if (pend) begin
            n_chk++; if (rsp_err_o !== pend_err) begin n_err++; $display("FAIL idle_rsp_err: got %b want %b", rsp_err_o, pend_err); end
        end
        n_chk++; if (rsp_rdata_o !== m_rdata) begin n_err++; $display("FAIL idle_rdata: got %h want %h", rsp_rdata_o, m_rdata); end
        n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy_o); end
        n_chk++; if (htrans_o !== 2'b00) begin n_err++; $display("FAIL idle_htrans: got %b want 00", htrans_o); end
        n_chk++; if (req_gnt_o !== 1'b0) begin n_err++; $display("FAIL idle_gnt: got %b want 0", req_gnt_o); end
        n_chk++; if (tmo_o !== m_tmo) begin n_err++; $display("FAIL idle_tmo: got %b want %b", tmo_o, m_tmo); end
        pend = 1'b0;
        if (clr) m_tmo = 1'b0;
    endtask

    // One transfer from its grant cycle to its last bus cycle. The response is left pending
    // and checked by whichever cycle comes next (idle or the grant of a chained transfer).
    // emode: 0 OKAY, 1 two-cycle ERROR, 2 single-cycle ERROR.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int astall, input int nwait, input int emode,
                        input logic [31:0] rdata, input bit hold_req, input bit clr_data);
        int d0, last, waits;
        @(posedge clk); #1;
        req_i = 1'b1; req_wr_i = wr; req_addr_i = addr; req_wdata_i = wdata;
        hready_i = 1'b1; hresp_i = 2'b00; tmo_clr_i = 1'b0; hrdata_i = $urandom;
        @(negedge clk);
        n_chk++; if (req_gnt_o !== 1'b1) begin n_err++; $display("FAIL grant: got %b want 1", req_gnt_o); end
        n_chk++; if (htrans_o !== 2'b00) begin n_err++; $display("FAIL grant_htrans: got %b want 00", htrans_o); end
        n_chk++; if (rsp_vld_o !== pend) begin n_err++; $display("FAIL grant_rsp_vld: got %b want %b", rsp_vld_o, pend); end
        if (pend) begin
            n_chk++; if (rsp_err_o !== pend_err) begin n_err++; $display("FAIL grant_rsp_err: got %b want %b", rsp_err_o, pend_err); end
        end
        n_chk++; if (rsp_rdata_o !== m_rdata) begin n_err++; $display("FAIL grant_rdata: got %h want %h", rsp_rdata_o, m_rdata); end
        n_chk++; if (tmo_o !== m_tmo) begin n_err++; $display("FAIL grant_tmo: got %b want %b", tmo_o, m_tmo); end
        pend = 1'b0;
        if (addr[1:0] != 2'b00) begin
            pend = 1'b1; pend_err = 1'b1;
            return;
        end
        d0    = astall + 2;
        last  = d0 + nwait + ((emode == 1) ? 1 : 0);
        waits = 0;
        for (int t = 1; t <= last; t++) begin
            @(posedge clk); #1;
            req_i = hold_req;
            req_wr_i = $urandom_range(0, 1); req_addr_i = $urandom; req_wdata_i = $urandom;
            hrdata_i = $urandom;
            tmo_clr_i = clr_data && (t >= d0) && (t < d0 + MAXW);
            if (t < d0) begin
                hready_i = (t > astall); hresp_i = 2'b00;
            end else if (t < d0 + nwait) begin
                hready_i = 1'b0; hresp_i = 2'b00;
            end else if (emode == 1 && t == d0 + nwait) begin
                hready_i = 1'b0; hresp_i = 2'b01;
            end else begin
                hready_i = 1'b1; hresp_i = (emode != 0) ? 2'b01 : 2'b00; hrdata_i = rdata;
            end
            @(negedge clk);
            n_chk++; if (req_gnt_o !== 1'b0) begin n_err++; $display("FAIL busy_gnt t=%0d: got %b want 0", t, req_gnt_o); end
            n_chk++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL busy t=%0d: got %b want 1", t, busy_o); end
            n_chk++; if (rsp_vld_o !== 1'b0) begin n_err++; $display("FAIL early_rsp t=%0d: got %b want 0", t, rsp_vld_o); end
            n_chk++; if (rsp_rdata_o !== m_rdata) begin n_err++; $display("FAIL held_rdata t=%0d: got %h want %h", t, rsp_rdata_o, m_rdata); end
            n_chk++; if (tmo_o !== m_tmo) begin n_err++; $display("FAIL tmo t=%0d: got %b want %b", t, tmo_o, m_tmo); end
            if (t < d0) begin
                n_chk++; if (htrans_o !== 2'b10) begin n_err++; $display("FAIL addr_htrans t=%0d: got %b want 10", t, htrans_o); end
                n_chk++; if (haddr_o !== addr) begin n_err++; $display("FAIL addr_haddr t=%0d: got %h want %h", t, haddr_o, addr); end
                n_chk++; if (hwrite_o !== wr) begin n_err++; $display("FAIL addr_hwrite t=%0d: got %b want %b", t, hwrite_o, wr); end
            end else begin
                n_chk++; if (htrans_o !== 2'b00) begin n_err++; $display("FAIL data_htrans t=%0d: got %b want 00", t, htrans_o); end
                n_chk++; if (hwdata_o !== wdata) begin n_err++; $display("FAIL data_hwdata t=%0d: got %h want %h", t, hwdata_o, wdata); end
                if (!hready_i) waits++;
            end
            if (t >= d0 && !hready_i && waits >= MAXW) m_tmo = 1'b1;
            else if (tmo_clr_i) m_tmo = 1'b0;
        end
        pend = 1'b1;
        pend_err = (emode != 0);
        if (emode == 0 && !wr) m_rdata = rdata;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_i = 1'b0; req_wr_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        tmo_clr_i = 1'b0; hready_i = 1'b1; hresp_i = 2'b00; hrdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (htrans_o !== 2'b00) begin n_err++; $display("FAIL rst_htrans: got %b want 00", htrans_o); end
        n_chk++; if (haddr_o !== 32'h0) begin n_err++; $display("FAIL rst_haddr: got %h want 0", haddr_o); end
        n_chk++; if (hwdata_o !== 32'h0) begin n_err++; $display("FAIL rst_hwdata: got %h want 0", hwdata_o); end
        n_chk++; if ({busy_o, rsp_vld_o, rsp_err_o, tmo_o, hwrite_o} !== 5'b0) begin n_err++; $display("FAIL rst_flags: got %b want 00000", {busy_o, rsp_vld_o, rsp_err_o, tmo_o, hwrite_o}); end
        n_chk++; if (rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata_o); end
        n_chk++; if ({hsize_o, hburst_o, hmastlock_o} !== 7'b010_000_0) begin n_err++; $display("FAIL rst_const: got %b want 0100000", {hsize_o, hburst_o, hmastlock_o}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait;
        xfer(1'b1, 32'h1000_0010, 32'hA5A5_5A5A, 0, 0, 0, 32'h0, 1'b0, 1'b0);
        idle_cycle(1'b0);
    endtask

    task automatic test_read_waits;
        xfer(1'b0, 32'h1000_0004, 32'h0BAD_F00D, 0, 3, 0, 32'h0000_00FF, 1'b0, 1'b0);
        idle_cycle(1'b0);
    endtask

    task automatic test_misaligned;
        xfer(1'b0, 32'h1000_0002, 32'h0, 0, 0, 0, 32'h0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
    endtask

    task automatic test_back_to_back;
        xfer(1'b1, 32'h1000_0020, 32'hDEAD_BEEF, 0, 0, 1, 32'h0, 1'b1, 1'b0);
        xfer(1'b0, 32'h1000_0024, 32'h0, 1, 0, 0, 32'h1357_9BDF, 1'b0, 1'b0);
        xfer(1'b0, 32'h1000_0028, 32'h0, 0, 1, 2, 32'hFFFF_0000, 1'b0, 1'b0);
        idle_cycle(1'b0);
    endtask

    task automatic test_timeout;
        xfer(1'b0, 32'h1000_0030, 32'h0, 0, 6, 0, 32'h00C0_FFEE, 1'b0, 1'b0);
        idle_cycle(1'b0);
        xfer(1'b1, 32'h1000_0034, 32'h7777_1111, 0, 5, 0, 32'h0, 1'b0, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            int r, em;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            r  = $urandom_range(0, 9);
            em = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                 em, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycle(1'b0);
        end
        idle_cycle(1'b1);
        idle_cycle(1'b0);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        req_i = 1'b1; req_wr_i = 1'b1; req_addr_i = 32'h2000_0008; req_wdata_i = 32'h1234_5678;
        hready_i = 1'b1; hresp_i = 2'b00; tmo_clr_i = 1'b0;
        @(negedge clk);
        n_chk++; if (req_gnt_o !== 1'b1) begin n_err++; $display("FAIL rm_grant: got %b want 1", req_gnt_o); end
        @(posedge clk); #1;
        req_i = 1'b0;
        @(negedge clk);
        n_chk++; if (htrans_o !== 2'b10) begin n_err++; $display("FAIL rm_htrans: got %b want 10", htrans_o); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            hready_i = 1'b0;
            @(negedge clk);
            n_chk++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rm_busy k=%0d: got %b want 1", k, busy_o); end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (tmo_o !== 1'b1) begin n_err++; $display("FAIL rm_tmo_before: got %b want 1", tmo_o); end
        @(posedge clk); #1;
        rst = 1'b0; hready_i = 1'b1;
        @(negedge clk);
        n_chk++; if (htrans_o !== 2'b00) begin n_err++; $display("FAIL rm_htrans_rst: got %b want 00", htrans_o); end
        n_chk++; if (haddr_o !== 32'h0) begin n_err++; $display("FAIL rm_haddr: got %h want 0", haddr_o); end
        n_chk++; if (hwdata_o !== 32'h0) begin n_err++; $display("FAIL rm_hwdata: got %h want 0", hwdata_o); end
        n_chk++; if ({busy_o, rsp_vld_o, rsp_err_o, tmo_o, hwrite_o} !== 5'b0) begin n_err++; $display("FAIL rm_flags: got %b want 00000", {busy_o, rsp_vld_o, rsp_err_o, tmo_o, hwrite_o}); end
        n_chk++; if (rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL rm_rdata: got %h want 0", rsp_rdata_o); end
        pend = 1'b0; m_tmo = 1'b0; m_rdata = 32'h0;
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        xfer(1'b0, 32'h2000_000C, 32'h0, 1, 1, 0, 32'hCAFE_0001, 1'b0, 1'b0);
        idle_cycle(1'b0);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_misaligned();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
